// File: rtl/bin_to_bcd2_pkg.sv
// Shared types and constants for the 2-digit binary-to-BCD converter.
package bin_to_bcd2_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int MAX_VAL_DEF = 99;
  localparam int BIN_W       = 7;
  localparam int DIG_W       = 4;
  localparam int NUM_DIG     = 2;
  localparam int CNT_W       = 3;
  localparam int SR_W        = NUM_DIG * DIG_W + BIN_W;

  localparam logic [DIG_W-1:0] OVF_CODE = 4'hE;
  localparam logic [CNT_W-1:0] SHIFTS   = 3'd7;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: bump a digit >=5 by 3 so the next shift carries.
module bcd_add3
  import bin_to_bcd2_pkg::*;
(
  input  logic [DIG_W-1:0] digit,
  output logic [DIG_W-1:0] corrected
);
  assign corrected = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/bin_to_bcd2.sv
// Serial double-dabble converter: 7-bit binary to two BCD digits for a 7-seg driver.
module bin_to_bcd2
  import bin_to_bcd2_pkg::*;
#(
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [BIN_W-1:0] binIn,
  output logic             busy,
  output logic             done,
  output logic [DIG_W-1:0] hex1,
  output logic [DIG_W-1:0] hex0,
  output logic             ovf
);
  localparam logic [BIN_W-1:0] MAX_V = BIN_W'(MAX_VAL);

  state_t                              state;
  logic [CNT_W-1:0]                    cnt;
  logic [BIN_W-1:0]                    sr;
  logic [NUM_DIG-1:0][DIG_W-1:0]       bcd;
  logic [NUM_DIG-1:0][DIG_W-1:0]       corr;
  logic [SR_W-1:0]                     cat;
  logic [SR_W-1:0]                     sh;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    bcd_add3 u_add3 (.digit(bcd[g]), .corrected(corr[g]));
  end

  assign cat = {corr, sr};
  assign sh  = {cat[SR_W-2:0], 1'b0};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hex1  <= '0;
      hex0  <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
      sr    <= '0;
      bcd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (binIn > MAX_V) begin
              state <= DONE;
              done  <= 1'b1;
              hex1  <= OVF_CODE;
              hex0  <= OVF_CODE;
              ovf   <= 1'b1;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
              sr    <= binIn;
              bcd   <= '0;
              cnt   <= SHIFTS;
            end
          end
        end
        SHIFT: begin
          bcd <= sh[SR_W-1 -: NUM_DIG*DIG_W];
          sr  <= sh[BIN_W-1:0];
          cnt <= cnt - 1'b1;
          // Last shift lands the digits straight on the outputs.
          if (cnt == 3'd1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hex1  <= sh[SR_W-1 -: DIG_W];
            hex0  <= sh[SR_W-1-DIG_W -: DIG_W];
            ovf   <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/bin_to_bcd2.md
BIN_TO_BCD2 -- requirements
Module: bin_to_bcd2

Interface
REQ-001 Parameter MAX_VAL, default 99, largest binary value converted; larger inputs flag overflow.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rstN  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  conversion request, sampled only in IDLE.
REQ-005 binIn  input  7  unsigned binary value, sampled in the cycle start is accepted.
REQ-006 busy  output  1  high while a conversion is in progress (SHIFT state).
REQ-007 done  output  1  single-cycle pulse when hex1/hex0/ovf carry a new result.
REQ-008 hex1  output  4  tens digit for the 2-digit 7-segment driver.
REQ-009 hex0  output  4  units digit for the 2-digit 7-segment driver.
REQ-010 ovf  output  1  last accepted binIn exceeded MAX_VAL.

Function
REQ-011 FSM states IDLE, SHIFT, DONE; one-hot or binary encoding is an implementation choice.
REQ-012 IDLE with start=1 and binIn<=MAX_VAL: latch binIn into shift register, clear BCD scratch, set bit counter to 7, go SHIFT.
REQ-013 IDLE with start=1 and binIn>MAX_VAL: go DONE directly, result hex1=hex0=4'hE, ovf=1.
REQ-014 IDLE with start=0: remain IDLE; outputs hold.
REQ-015 SHIFT, each cycle: add 3 to each scratch BCD digit >=5, then shift {tens,units,bin} left one bit, decrement counter.
REQ-016 SHIFT exits to DONE on the cycle the counter reaches 0; exactly 7 SHIFT cycles per conversion.
REQ-017 Latency: start accepted at edge N; valid path done=1 during cycle after edge N+8; overflow path done=1 after edge N+1.
REQ-018 hex1, hex0, ovf update only on the edge entering DONE; stable at all other times, including throughout SHIFT.
REQ-019 Valid result: ovf=0, hex1/hex0 = decimal tens/units of binIn, each 0..9.
REQ-020 DONE lasts exactly one cycle, then IDLE unconditionally; start asserted in DONE or SHIFT is ignored, not queued.
REQ-021 busy=1 exactly in SHIFT; done=1 exactly in DONE; never both high.
REQ-022 binIn changes after acceptance have no effect on the running conversion.
REQ-023 Scratch digits 4 bits each; the add-3 correction never produces a digit >9 after the shift for inputs <=99.

Reset
REQ-024 rstN=0 asynchronously forces IDLE, busy=0, done=0, hex1=0, hex0=0, ovf=0, counter=0, scratch=0.
REQ-025 Reset during SHIFT aborts the conversion; no done pulse is generated for it.
REQ-026 After rstN deasserts, the first start is accepted no earlier than the first rising clk edge with rstN=1.

Structure
REQ-027 Shared package holds state encodings, MAX_VAL default, input width 7, BCD digit width 4, overflow code 4'hE.
REQ-028 One combinational sub-module bcd_add3 (4-bit in, 4-bit out: in>=5 ? in+3 : in), instantiated once per digit.
REQ-029 hex1/hex0 connect directly to the 2-digit 7-segment driver's digit inputs; no extra pipeline stage.

Verification
REQ-030 Reset, then start with binIn=42 -> busy high 7 cycles, done pulse 8 cycles after accept, hex1=4, hex0=2, ovf=0.
REQ-031 Exhaustive binIn 0..99 back-to-back (start held high) -> each result matches decimal split; one accept per 9 cycles.
REQ-032 binIn=100 and binIn=127 -> done 1 cycle after accept, hex1=hex0=4'hE, ovf=1; next binIn=7 gives hex1=0, hex0=7, ovf=0.
REQ-033 Start pulsed during SHIFT and DONE with binIn=99 while converting 15 -> result 1/5 only, no second done pulse.
REQ-034 rstN low at 3rd SHIFT cycle converting 88 -> outputs 0 immediately, no done; after release, start 88 -> 8/8.
REQ-035 binIn changed every cycle during SHIFT after accepting 63 -> result 6/3.
